// File: rtl/instrq_extra_feed.sv
// instrq_extra_feed
//
// Write-side feeder for the per-thread instruction-extra queue. Each accepted
// 4-slot fetch bundle is compacted so its valid extra entries sit, in age
// order, at the top of a 4-wide write (youngest in slot 3). A registered
// output stage (OUT) drives the queue write port, and a one-bundle skid
// register (SKID) absorbs queue back-pressure. An exception flushes
// everything belonging to the named thread.
//
// Configuration macro: INSTRQ_EXTRA_FEED_PERF_EN adds the PERF_W parameter
// and the stall_cycles port (saturating count of stalled cycles with OUT
// holding data). Without the macro neither exists.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   except, except_thread     flush request and the thread being flushed
//   in_valid / in_ready       bundle handshake
//   in_thread, in_mask        bundle thread, per-slot valid (slot0 = oldest)
//   in_data0..3               slot payloads
//   fStall, doFStall          queue back-pressure (doFStall is combinational)
//   write_wen, write_thread   queue write strobe and thread
//   write_cnt                 one-hot entry count (bit k = k entries)
//   write_start               one-hot first occupied slot (bit4 = empty)
//   write_data0..3            right-justified entries
//   stall_cycles              optional perf counter

`ifndef instrQExtra_width
`define instrQExtra_width 32
`endif

module instrq_extra_feed #(
  parameter int DATA_WIDTH = `instrQExtra_width
`ifdef INSTRQ_EXTRA_FEED_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  except,
  input  logic                  except_thread,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_thread,
  input  logic [3:0]            in_mask,
  input  logic [DATA_WIDTH-1:0] in_data0,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [DATA_WIDTH-1:0] in_data2,
  input  logic [DATA_WIDTH-1:0] in_data3,
  input  logic                  fStall,
  input  logic                  doFStall,
  output logic                  write_wen,
  output logic                  write_thread,
  output logic [4:0]            write_cnt,
  output logic [4:0]            write_start,
  output logic [DATA_WIDTH-1:0] write_data0,
  output logic [DATA_WIDTH-1:0] write_data1,
  output logic [DATA_WIDTH-1:0] write_data2,
  output logic [DATA_WIDTH-1:0] write_data3
`ifdef INSTRQ_EXTRA_FEED_PERF_EN
  , output logic [PERF_W-1:0]   stall_cycles
`endif
);

  logic [DATA_WIDTH-1:0] in_data  [4];
  logic [DATA_WIDTH-1:0] new_data [4];
  logic [2:0]            new_n;
  logic [1:0]            slot;
  logic [4:0]            new_cnt;
  logic [4:0]            new_start;

  logic                  out_valid;
  logic                  out_thread;
  logic [4:0]            out_cnt;
  logic [4:0]            out_start;
  logic [DATA_WIDTH-1:0] out_data [4];

  logic                  skid_valid;
  logic                  skid_thread;
  logic [4:0]            skid_cnt;
  logic [4:0]            skid_start;
  logic [DATA_WIDTH-1:0] skid_data [4];

  logic out_live;
  logic skid_live;
  logic accept;
  logic take_new;
  logic adv;

  assign in_data[0] = in_data0;
  assign in_data[1] = in_data1;
  assign in_data[2] = in_data2;
  assign in_data[3] = in_data3;

  // Compaction: the first valid entry lands at slot 4-n and each later one
  // takes the next slot up, so the youngest always ends in slot 3. The 2-bit
  // slot pointer may wrap after the last write, but it is never used then.
  always_comb begin
    new_n = 3'd0;
    for (int i = 0; i < 4; i++) new_n = new_n + 3'(in_mask[i]);
    for (int i = 0; i < 4; i++) new_data[i] = '0;
    slot = 2'(3'd4 - new_n);
    for (int i = 0; i < 4; i++) begin
      if (in_mask[i]) begin
        new_data[slot] = in_data[i];
        slot = slot + 2'd1;
      end
    end
  end

  // 1<<(4-n) already yields 5'b00001 for n=4 and 5'b10000 for n=0.
  assign new_cnt   = 5'b00001 << new_n;
  assign new_start = 5'b00001 << (3'd4 - new_n);

  // Flush qualification: a register survives only if it is not for the
  // flushed thread. A killed OUT cannot write and frees up for the SKID.
  assign out_live  = out_valid  & ~(except & (out_thread  == except_thread));
  assign skid_live = skid_valid & ~(except & (skid_thread == except_thread));

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign take_new  = accept & (new_n != 3'd0)
                   & ~(except & (in_thread == except_thread));

  assign write_wen = out_live & ~fStall & ~doFStall & ~rst;
  assign adv       = ~out_live | write_wen;

  // OUT/SKID update. When OUT advances, SKID (older) wins over a new bundle;
  // a new bundle can only arrive while SKID is empty since in_ready=~skid_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_thread  <= 1'b0;
      out_cnt     <= 5'b00001;
      out_start   <= 5'b10000;
      skid_valid  <= 1'b0;
      skid_thread <= 1'b0;
      skid_cnt    <= 5'b00001;
      skid_start  <= 5'b10000;
      for (int i = 0; i < 4; i++) begin
        out_data[i]  <= '0;
        skid_data[i] <= '0;
      end
    end else if (adv) begin
      if (skid_live) begin
        out_valid  <= 1'b1;
        out_thread <= skid_thread;
        out_cnt    <= skid_cnt;
        out_start  <= skid_start;
        out_data   <= skid_data;
      end else if (take_new) begin
        out_valid  <= 1'b1;
        out_thread <= in_thread;
        out_cnt    <= new_cnt;
        out_start  <= new_start;
        out_data   <= new_data;
      end else begin
        out_valid  <= 1'b0;
      end
      skid_valid <= 1'b0;
    end else begin
      out_valid <= out_live;
      if (take_new) begin
        skid_valid  <= 1'b1;
        skid_thread <= in_thread;
        skid_cnt    <= new_cnt;
        skid_start  <= new_start;
        skid_data   <= new_data;
      end else begin
        skid_valid  <= skid_live;
      end
    end
  end

  assign write_thread = out_thread;
  assign write_cnt    = out_cnt;
  assign write_start  = out_start;
  assign write_data0  = out_data[0];
  assign write_data1  = out_data[1];
  assign write_data2  = out_data[2];
  assign write_data3  = out_data[3];

`ifdef INSTRQ_EXTRA_FEED_PERF_EN
  // Saturating count of cycles where OUT holds data but the queue refuses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (out_valid & (fStall | doFStall) & ~(&stall_cycles)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instrq_extra_feed.sv
// tb_instrq_extra_feed
//
// Directed self-checking bench for instrq_extra_feed. Inputs change on the
// falling edge and outputs are sampled 1 time unit later, well clear of the
// rising (active) edge. Build with INSTRQ_EXTRA_FEED_PERF_EN to also cover
// the stall counter.

module tb_instrq_extra_feed;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          except = 1'b0;
  logic          except_thread = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_thread = 1'b0;
  logic [3:0]    in_mask = 4'b0000;
  logic [DW-1:0] in_data0 = '0;
  logic [DW-1:0] in_data1 = '0;
  logic [DW-1:0] in_data2 = '0;
  logic [DW-1:0] in_data3 = '0;
  logic          fStall = 1'b0;
  logic          doFStall = 1'b0;
  logic          write_wen;
  logic          write_thread;
  logic [4:0]    write_cnt;
  logic [4:0]    write_start;
  logic [DW-1:0] write_data0;
  logic [DW-1:0] write_data1;
  logic [DW-1:0] write_data2;
  logic [DW-1:0] write_data3;
`ifdef INSTRQ_EXTRA_FEED_PERF_EN
  logic [15:0]   stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [DW-1:0] A = 32'hA000_000A;
  localparam logic [DW-1:0] B = 32'hB000_000B;
  localparam logic [DW-1:0] C = 32'hC000_000C;
  localparam logic [DW-1:0] D = 32'hD000_000D;
  localparam logic [DW-1:0] X = 32'hEEEE_EEEE;
  localparam logic [DW-1:0] F = 32'hF000_000F;
  localparam logic [DW-1:0] G = 32'h6000_0006;

  instrq_extra_feed #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .except(except),
    .except_thread(except_thread),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_thread(in_thread),
    .in_mask(in_mask),
    .in_data0(in_data0),
    .in_data1(in_data1),
    .in_data2(in_data2),
    .in_data3(in_data3),
    .fStall(fStall),
    .doFStall(doFStall),
    .write_wen(write_wen),
    .write_thread(write_thread),
    .write_cnt(write_cnt),
    .write_start(write_start),
    .write_data0(write_data0),
    .write_data1(write_data1),
    .write_data2(write_data2),
    .write_data3(write_data3)
`ifdef INSTRQ_EXTRA_FEED_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic t, input logic [3:0] m,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    in_valid  = v;
    in_thread = t;
    in_mask   = m;
    in_data0  = d0;
    in_data1  = d1;
    in_data2  = d2;
    in_data3  = d3;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'b0000, '0, '0, '0, '0);
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; idle();
    @(negedge clk);
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (write_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen got=%0b exp=0", write_wen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%0b exp=1", in_ready); end
    checks++; if ({write_cnt, write_start} !== {5'b00001, 5'b10000}) begin errors++; $display("[TB] FAIL reset_cnt_start got=%b_%b exp=00001_10000", write_cnt, write_start); end
    checks++; if ({write_thread, write_data0, write_data1, write_data2, write_data3} !== '0) begin errors++; $display("[TB] FAIL reset_data got=%0b %h %h %h %h exp=0", write_thread, write_data0, write_data1, write_data2, write_data3); end
`ifdef INSTRQ_EXTRA_FEED_PERF_EN
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall got=%0d exp=0", stall_cycles); end
`endif
  endtask

  task automatic test_full_mask();
    @(negedge clk); drive(1'b1, 1'b0, 4'b1111, A, B, C, D); #1;
    checks++; if ({in_ready, write_wen} !== 2'b10) begin errors++; $display("[TB] FAIL full_offer got=%b exp=10", {in_ready, write_wen}); end
    @(negedge clk); idle(); #1;
    checks++; if ({write_wen, write_thread} !== 2'b10) begin errors++; $display("[TB] FAIL full_wen got=%b exp=10", {write_wen, write_thread}); end
    checks++; if ({write_cnt, write_start} !== {5'b10000, 5'b00001}) begin errors++; $display("[TB] FAIL full_cnt_start got=%b_%b exp=10000_00001", write_cnt, write_start); end
    checks++; if ({write_data0, write_data1, write_data2, write_data3} !== {A, B, C, D}) begin errors++; $display("[TB] FAIL full_data got=%h %h %h %h exp=%h %h %h %h", write_data0, write_data1, write_data2, write_data3, A, B, C, D); end
    @(negedge clk); #1;
    checks++; if (write_wen !== 1'b0) begin errors++; $display("[TB] FAIL full_drain got=%0b exp=0", write_wen); end
  endtask

  task automatic test_sparse_mask();
    @(negedge clk); drive(1'b1, 1'b1, 4'b0101, A, X, C, X);
    @(negedge clk); drive(1'b1, 1'b0, 4'b0010, X, B, X, X); #1;
    checks++; if ({write_wen, write_thread} !== 2'b11) begin errors++; $display("[TB] FAIL sparse_wen got=%b exp=11", {write_wen, write_thread}); end
    checks++; if ({write_cnt, write_start} !== {5'b00100, 5'b00100}) begin errors++; $display("[TB] FAIL sparse_cnt_start got=%b_%b exp=00100_00100", write_cnt, write_start); end
    checks++; if ({write_data0, write_data1, write_data2, write_data3} !== {32'h0, 32'h0, A, C}) begin errors++; $display("[TB] FAIL sparse_data got=%h %h %h %h exp=0 0 %h %h", write_data0, write_data1, write_data2, write_data3, A, C); end
    @(negedge clk); idle(); #1;
    checks++; if ({write_wen, write_thread} !== 2'b10) begin errors++; $display("[TB] FAIL single_wen got=%b exp=10", {write_wen, write_thread}); end
    checks++; if ({write_cnt, write_start} !== {5'b00010, 5'b01000}) begin errors++; $display("[TB] FAIL single_cnt_start got=%b_%b exp=00010_01000", write_cnt, write_start); end
    checks++; if ({write_data0, write_data1, write_data2, write_data3} !== {32'h0, 32'h0, 32'h0, B}) begin errors++; $display("[TB] FAIL single_data got=%h %h %h %h exp=0 0 0 %h", write_data0, write_data1, write_data2, write_data3, B); end
    @(negedge clk); #1;
    checks++; if (write_wen !== 1'b0) begin errors++; $display("[TB] FAIL sparse_drain got=%0b exp=0", write_wen); end
  endtask

  task automatic test_empty_mask();
    @(negedge clk); drive(1'b1, 1'b0, 4'b0001, A, X, X, X);
    @(negedge clk); fStall = 1'b1; drive(1'b1, 1'b1, 4'b0000, B, C, D, X); #1;
    checks++; if ({in_ready, write_wen} !== 2'b10) begin errors++; $display("[TB] FAIL empty_offer got=%b exp=10", {in_ready, write_wen}); end
    @(negedge clk); idle(); #1;
    checks++; if ({in_ready, write_wen, write_thread} !== 3'b100) begin errors++; $display("[TB] FAIL empty_hold got=%b exp=100", {in_ready, write_wen, write_thread}); end
    checks++; if ({write_cnt, write_data3} !== {5'b00010, A}) begin errors++; $display("[TB] FAIL empty_out got=%b %h exp=00010 %h", write_cnt, write_data3, A); end
    @(negedge clk); fStall = 1'b0; #1;
    checks++; if ({write_wen, write_data3} !== {1'b1, A}) begin errors++; $display("[TB] FAIL empty_release got=%b %h exp=1 %h", write_wen, write_data3, A); end
    @(negedge clk); #1;
    checks++; if (write_wen !== 1'b0) begin errors++; $display("[TB] FAIL empty_discard got=%0b exp=0", write_wen); end
  endtask

  task automatic test_stall();
    @(negedge clk); rst = 1'b1; idle();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); drive(1'b1, 1'b0, 4'b1111, 32'd1, 32'd2, 32'd3, 32'd4);
    @(negedge clk); doFStall = 1'b1; drive(1'b1, 1'b0, 4'b0011, 32'd5, 32'd6, 32'd0, 32'd0); #1;
    checks++; if ({in_ready, write_wen} !== 2'b10) begin errors++; $display("[TB] FAIL stall_c1 got=%b exp=10", {in_ready, write_wen}); end
    @(negedge clk); idle(); #1;
    checks++; if ({in_ready, write_wen} !== 2'b00) begin errors++; $display("[TB] FAIL stall_c2 got=%b exp=00", {in_ready, write_wen}); end
    @(negedge clk); #1;
    checks++; if ({in_ready, write_wen} !== 2'b00) begin errors++; $display("[TB] FAIL stall_c3 got=%b exp=00", {in_ready, write_wen}); end
    @(negedge clk); doFStall = 1'b0; #1;
    checks++; if ({in_ready, write_wen} !== 2'b01) begin errors++; $display("[TB] FAIL stall_rel1 got=%b exp=01", {in_ready, write_wen}); end
    checks++; if ({write_data0, write_data1, write_data2, write_data3} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin errors++; $display("[TB] FAIL stall_rel1_data got=%h %h %h %h exp=1 2 3 4", write_data0, write_data1, write_data2, write_data3); end
`ifdef INSTRQ_EXTRA_FEED_PERF_EN
    checks++; if (stall_cycles !== 16'd3) begin errors++; $display("[TB] FAIL stall_count got=%0d exp=3", stall_cycles); end
`endif
    @(negedge clk); #1;
    checks++; if ({in_ready, write_wen} !== 2'b11) begin errors++; $display("[TB] FAIL stall_rel2 got=%b exp=11", {in_ready, write_wen}); end
    checks++; if ({write_cnt, write_start, write_data0, write_data1, write_data2, write_data3} !== {5'b00100, 5'b00100, 32'd0, 32'd0, 32'd5, 32'd6}) begin errors++; $display("[TB] FAIL stall_rel2_out got=%b %b %h %h %h %h exp=00100 00100 0 0 5 6", write_cnt, write_start, write_data0, write_data1, write_data2, write_data3); end
    @(negedge clk); #1;
    checks++; if (write_wen !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain got=%0b exp=0", write_wen); end
  endtask

  task automatic test_except();
    @(negedge clk); drive(1'b1, 1'b1, 4'b1111, A, B, C, D);
    @(negedge clk); doFStall = 1'b1; drive(1'b1, 1'b0, 4'b0001, F, X, X, X);
    @(negedge clk); doFStall = 1'b0; idle(); except = 1'b1; except_thread = 1'b1; #1;
    checks++; if ({in_ready, write_wen} !== 2'b00) begin errors++; $display("[TB] FAIL except_kill got=%b exp=00", {in_ready, write_wen}); end
    @(negedge clk); except = 1'b0; #1;
    checks++; if ({write_wen, write_thread, write_cnt, write_data3} !== {1'b1, 1'b0, 5'b00010, F}) begin errors++; $display("[TB] FAIL except_survivor got=%b %b %b %h exp=1 0 00010 %h", write_wen, write_thread, write_cnt, write_data3, F); end
    @(negedge clk); except = 1'b1; drive(1'b1, 1'b1, 4'b1111, A, B, C, D); #1;
    checks++; if ({in_ready, write_wen} !== 2'b10) begin errors++; $display("[TB] FAIL except_drop_offer got=%b exp=10", {in_ready, write_wen}); end
    @(negedge clk); drive(1'b1, 1'b0, 4'b0001, G, X, X, X); #1;
    checks++; if (write_wen !== 1'b0) begin errors++; $display("[TB] FAIL except_dropped got=%0b exp=0", write_wen); end
    @(negedge clk); except = 1'b0; idle(); #1;
    checks++; if ({write_wen, write_thread, write_data3} !== {1'b1, 1'b0, G}) begin errors++; $display("[TB] FAIL except_other_thread got=%b %b %h exp=1 0 %h", write_wen, write_thread, write_data3, G); end
    @(negedge clk); #1;
    checks++; if (write_wen !== 1'b0) begin errors++; $display("[TB] FAIL except_drain got=%0b exp=0", write_wen); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1'b1, 1'b0, 4'b1111, A, B, C, D);
    @(negedge clk); doFStall = 1'b1; drive(1'b1, 1'b1, 4'b0011, A, B, X, X);
    @(negedge clk); idle(); rst = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_full got=%0b exp=0", in_ready); end
    @(negedge clk); rst = 1'b0; doFStall = 1'b0; #1;
    checks++; if ({write_wen, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL rstmid_hs got=%b exp=01", {write_wen, in_ready}); end
    checks++; if ({write_cnt, write_start} !== {5'b00001, 5'b10000}) begin errors++; $display("[TB] FAIL rstmid_cnt_start got=%b_%b exp=00001_10000", write_cnt, write_start); end
    @(negedge clk); #1;
    checks++; if (write_wen !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after got=%0b exp=0", write_wen); end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_empty_mask();
    test_stall();
    test_except();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
